// File: rtl/alu_issue_unit_if.sv
// alu_issue_unit_if: request/response handshake bundle between a requester and alu_issue_unit
// master: drives req_valid/op/a/b/keep_flags and resp_ready; sees req_ready and the response
// slave:  the issue unit side of the same signals
interface alu_issue_unit_if #(parameter int WIDTH = 16);
  logic req_valid, req_ready, req_keep_flags;
  logic [4:0] req_op;
  logic [WIDTH-1:0] req_a, req_b;
  logic resp_valid, resp_ready, resp_illegal;
  logic [WIDTH-1:0] resp_result;
  logic [5:0] resp_status;
  modport master(
    output req_valid, req_op, req_a, req_b, req_keep_flags, resp_ready,
    input req_ready, resp_valid, resp_result, resp_status, resp_illegal
  );
  modport slave(
    input req_valid, req_op, req_a, req_b, req_keep_flags, resp_ready,
    output req_ready, resp_valid, resp_result, resp_status, resp_illegal
  );
endinterface

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: two-stage issue/response front end for ALU_16 owning the {C,Z,N,V,P,AC} flag register
// clk, rst_n (sync, active-low); bus: request/response handshake (slave side)
// alu_*: operand/opcode/carry drive to ALU_16 and its result/status back
// flags, flag_load, flag_load_val: architectural flags and software write; done_cnt: completed ops
module alu_issue_unit #(parameter int WIDTH = 16) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_unit_if.slave  bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic             alu_cflag,
  output logic [4:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [5:0]       alu_status,
  output logic [5:0]       flags,
  input  logic             flag_load,
  input  logic [5:0]       flag_load_val,
  output logic [15:0]      done_cnt
);
  localparam logic [4:0] ADC = 5'b00101, SBB = 5'b00111, ROL = 5'b10100;
  localparam logic [4:0] ROR = 5'b10101, RCL = 5'b10110, RCR = 5'b10111;
  logic iss_v, iss_keep, capture, legal, c;
  logic [4:0] iss_op;
  logic [WIDTH-1:0] iss_a, iss_b;
  assign capture = iss_v && (!bus.resp_valid || bus.resp_ready);
  assign bus.req_ready = !iss_v || capture;
  // unassigned opcodes are 01100-01111 and 11000-11111
  assign legal = iss_op[4] ? !iss_op[3] : !(iss_op[3] && iss_op[2]);
  assign c = flags[5];
  always_comb begin
    alu_a = iss_v ? iss_a : '0;
    alu_b = iss_v ? iss_b : '0;
    alu_opcode = iss_v ? iss_op : '0;
    // C=1 means "no borrow", so SBB feeds the inverted carry
    alu_cin = !iss_v ? 1'b0 : iss_op == ADC ? c : iss_op == SBB ? !c : 1'b0;
    alu_cflag = !iss_v ? 1'b0 : iss_op == ROL ? iss_a[WIDTH-1] : iss_op == ROR ? iss_a[0] :
                (iss_op == RCL || iss_op == RCR) ? c : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_v <= 1'b0;
      iss_keep <= 1'b0;
      iss_op <= '0;
      iss_a <= '0;
      iss_b <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_result <= '0;
      bus.resp_status <= '0;
      bus.resp_illegal <= 1'b0;
      flags <= '0;
      done_cnt <= '0;
    end else begin
      if (bus.req_valid && bus.req_ready) begin
        iss_v <= 1'b1;
        iss_keep <= bus.req_keep_flags;
        iss_op <= bus.req_op;
        iss_a <= bus.req_a;
        iss_b <= bus.req_b;
      end else if (capture) begin
        iss_v <= 1'b0;
      end
      if (capture) begin
        bus.resp_valid <= 1'b1;
        bus.resp_result <= legal ? alu_result : '0;
        bus.resp_status <= legal ? alu_status : '0;
        bus.resp_illegal <= !legal;
        done_cnt <= done_cnt + 16'd1;
      end else if (bus.resp_ready) begin
        bus.resp_valid <= 1'b0;
      end
      if (flag_load) flags <= flag_load_val;
      else if (capture && legal && !iss_keep) flags <= alu_status;
    end
  end
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: directed scoreboard bench for alu_issue_unit with a behavioural ALU_16 stand-in
module tb_alu_issue_unit;
  localparam logic [4:0] OP_ADD = 5'b00100, OP_ADC = 5'b00101, OP_SUB = 5'b00110, OP_SBB = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b10100, OP_ROR = 5'b10101, OP_RCL = 5'b10110, OP_RCR = 5'b10111;
  localparam logic [4:0] OP_BAD = 5'b11000;
  typedef struct packed {
    logic [15:0] r;
    logic [5:0] s;
    logic ill;
    logic cs;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_issue_unit_if bus();
  logic [15:0] alu_a, alu_b, alu_result, done_cnt;
  logic alu_cin, alu_cflag, flag_load;
  logic [4:0] alu_opcode;
  logic [5:0] alu_status, flags, flag_load_val;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  alu_issue_unit dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_cflag(alu_cflag), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_status(alu_status),
    .flags(flags), .flag_load(flag_load), .flag_load_val(flag_load_val), .done_cnt(done_cnt)
  );
  logic [16:0] wide;
  logic [4:0] nib;
  logic c_out, v_out, ac_out;
  always_comb begin
    wide = '0;
    nib = '0;
    c_out = 1'b0;
    v_out = 1'b0;
    ac_out = 1'b0;
    alu_result = alu_a;
    case (alu_opcode)
      OP_ADD, OP_ADC: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_cin);
        nib = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + 5'(alu_cin);
        alu_result = wide[15:0];
        c_out = wide[16];
        ac_out = nib[4];
        v_out = (alu_a[15] == alu_b[15]) && (wide[15] != alu_a[15]);
      end
      OP_SUB, OP_SBB: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b} - 17'(alu_cin);
        alu_result = wide[15:0];
        c_out = !wide[16];
      end
      OP_ROL, OP_RCL: begin
        alu_result = {alu_a[14:0], alu_cflag};
        c_out = alu_a[15];
      end
      OP_ROR, OP_RCR: begin
        alu_result = {alu_cflag, alu_a[15:1]};
        c_out = alu_a[0];
      end
      default: ;
    endcase
    alu_status = {c_out, alu_result == 16'h0, alu_result[15], v_out, ~^alu_result[7:0], ac_out};
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got result %0h expected no response", bus.resp_result);
      end else begin
        e = q.pop_front();
        check("resp_result", 32'(bus.resp_result), 32'(e.r));
        check("resp_illegal", 32'(bus.resp_illegal), 32'(e.ill));
        if (e.cs) check("resp_status", 32'(bus.resp_status), 32'(e.s));
      end
    end
  end
  task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, input logic keep,
                       input logic [15:0] er, input logic [5:0] es, input logic cs, input logic ill);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_keep_flags = keep;
    #1;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1 for op %0h", op);
    end else begin
      q.push_back('{r: er, s: es, ill: ill, cs: cs});
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.resp_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", 32'(q.size()) | 32'(bus.resp_valid), 32'd0);
  endtask
  task automatic load_flags(input logic [5:0] v);
    flag_load = 1'b1;
    flag_load_val = v;
    @(posedge clk);
    #1;
    flag_load = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_keep_flags = 1'b0;
    bus.resp_ready = 1'b1;
    flag_load = 1'b0;
    flag_load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 6'b110011, 1'b1, 1'b0);
    issue(OP_ADC, 16'h0001, 16'hFFF0, 1'b0, 16'hFFF2, 6'b0, 1'b0, 1'b0);
    drain();
    check("chain_done_cnt", 32'(done_cnt), 32'd2);
    issue(OP_SUB, 16'h1000, 16'h1000, 1'b0, 16'h0000, 6'b0, 1'b0, 1'b0);
    drain();
    check("sub_flag_c", 32'(flags[5]), 32'd1);
    issue(OP_SBB, 16'h0005, 16'h0003, 1'b0, 16'h0002, 6'b0, 1'b0, 1'b0);
    drain();
    load_flags(6'b100000);
    check("load_flags", 32'(flags), 32'h20);
    issue(OP_RCL, 16'h0000, 16'h0000, 1'b0, 16'h0001, 6'b0, 1'b0, 1'b0);
    issue(OP_ROR, 16'h0001, 16'h0000, 1'b0, 16'h8000, 6'b0, 1'b0, 1'b0);
    drain();
    bus.resp_ready = 1'b0;
    issue(OP_ADD, 16'h0001, 16'h0001, 1'b0, 16'h0002, 6'b0, 1'b0, 1'b0);
    issue(OP_ADD, 16'h0002, 16'h0002, 1'b0, 16'h0004, 6'b0, 1'b0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_op = OP_ADD;
    bus.req_a = 16'h0003;
    bus.req_b = 16'h0003;
    bus.req_keep_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    check("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("bp_resp_hold", 32'(bus.resp_result), 32'h0002);
    q.push_back('{r: 16'h0006, s: 6'b0, ill: 1'b0, cs: 1'b0});
    bus.resp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    drain();
    load_flags(6'b100000);
    issue(OP_BAD, 16'h1234, 16'h5678, 1'b0, 16'h0000, 6'b000000, 1'b1, 1'b1);
    drain();
    check("illegal_flags", 32'(flags), 32'h20);
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 6'b110011, 1'b1, 1'b0);
    load_flags(6'b000100);
    drain();
    check("collision_flags", 32'(flags), 32'h04);
    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 6'b110011, 1'b1, 1'b0);
    drain();
    check("keep_flags", 32'(flags), 32'h04);
    bus.resp_ready = 1'b0;
    issue(OP_ADD, 16'h0010, 16'h0010, 1'b0, 16'h0020, 6'b0, 1'b0, 1'b0);
    issue(OP_ADD, 16'h0020, 16'h0020, 1'b0, 16'h0040, 6'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_resp_result", 32'(bus.resp_result), 32'd0);
    check("mid_rst_flags", 32'(flags), 32'd0);
    check("mid_rst_done_cnt", 32'(done_cnt), 32'd0);
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("post_rst_done_cnt", 32'(done_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
